// File: rtl/sdram_wb_bridge.sv
// Wishbone-style bus to sdram_top request/ack bridge: one registered SDRAM request per bus
// cycle, DQM byte masks, fixed-latency read capture and a lost-ack timeout watchdog.
module sdram_wb_bridge #(
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [1:0]  wb_sel,
  input  logic [20:0] wb_adr,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack,
  input  logic        sd_ready,
  output logic        sd_wr_req,
  output logic        sd_rd_req,
  input  logic        sd_wr_ack,
  input  logic        sd_rd_ack,
  output logic [21:0] sd_adr,
  output logic [15:0] sd_wdat,
  input  logic [15:0] sd_rdat,
  output logic        sd_udqm,
  output logic        sd_ldqm,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREQ  = 3'd1,
    ST_RREQ  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [7:0] RD_LAT_C  = 8'(RD_LAT);

  state_t     state_r;
  logic [7:0] cnt_r;
  logic       ack_r;

  // Ack is gated by the live strobe so a master that already walked away never sees it.
  assign wb_ack = ack_r & wb_stb;

  // Bridge sequencer: request issue, ack/timeout handling, read capture, bus acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      ack_r     <= 1'b0;
      wb_dat_o  <= 16'h0000;
      sd_wr_req <= 1'b0;
      sd_rd_req <= 1'b0;
      sd_adr    <= 22'd0;
      sd_wdat   <= 16'h0000;
      sd_udqm   <= 1'b0;
      sd_ldqm   <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r <= 1'b0;
          if (wb_stb && sd_ready) begin
            sd_adr  <= {1'b0, wb_adr};
            sd_wdat <= wb_dat_i;
            cnt_r   <= 8'd1;
            if (wb_we) begin
              sd_udqm <= ~wb_sel[1];
              sd_ldqm <= ~wb_sel[0];
              // A write with no byte enabled has nothing to send to the controller.
              if (wb_sel == 2'b00) begin
                ack_r   <= 1'b1;
                state_r <= ST_ACK;
              end else begin
                sd_wr_req <= 1'b1;
                state_r   <= ST_WREQ;
              end
            end else begin
              sd_udqm   <= 1'b0;
              sd_ldqm   <= 1'b0;
              sd_rd_req <= 1'b1;
              state_r   <= ST_RREQ;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WREQ: begin
          if (sd_wr_ack) begin
            sd_wr_req <= 1'b0;
            ack_r     <= 1'b1;
            state_r   <= ST_ACK;
          end else if (cnt_r >= TIMEOUT_C) begin
            sd_wr_req <= 1'b0;
            err       <= 1'b1;
            ack_r     <= 1'b1;
            state_r   <= ST_ACK;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_RREQ: begin
          if (sd_rd_ack) begin
            sd_rd_req <= 1'b0;
            cnt_r     <= 8'd1;
            state_r   <= ST_RWAIT;
          end else if (cnt_r >= TIMEOUT_C) begin
            sd_rd_req <= 1'b0;
            err       <= 1'b1;
            wb_dat_o  <= 16'hFFFF;
            ack_r     <= 1'b1;
            state_r   <= ST_ACK;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_RWAIT: begin
          // Read data is valid on the RD_LAT-th cycle after the controller accepted the read.
          if (cnt_r >= RD_LAT_C) begin
            wb_dat_o <= sd_rdat;
            ack_r    <= 1'b1;
            state_r  <= ST_ACK;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_ACK: begin
          if (!wb_stb) begin
            ack_r   <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            ack_r <= 1'b1;
          end
        end
        default: begin
          sd_wr_req <= 1'b0;
          sd_rd_req <= 1'b0;
          ack_r     <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_wb_bridge.md
# sdram_wb_bridge

Bus-side front end of the SDRAM subsystem: it sits between the processor's Wishbone-style memory port (sdram_stb/we/sel/adr/out/dat/ack) and the sdram_top controller's request/acknowledge port. Each bus cycle becomes exactly one registered write or read request, and the bridge drives the DQM byte masks. It captures read data after a fixed controller latency and returns a bus acknowledge. A timeout watchdog guarantees the processor never hangs on a lost controller acknowledge.

## Interface
Parameters:
- RD_LAT, 1: cycles from sd_rd_ack sampled high to sd_rdat valid (1..3)
- TIMEOUT, 255: maximum cycles with a request asserted before abort (8-bit counter, 2..255)

Ports:
- clk  in  1  single clock (100 MHz processor clock); all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wb_stb  in  1  bus transaction strobe; held high until wb_ack seen
- wb_we  in  1  1 = write, 0 = read
- wb_sel  in  2  byte enables [1]=high, [0]=low
- wb_adr  in  21  word address [21:1]
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data, registered
- wb_ack  out  1  transaction acknowledge
- sd_ready  in  1  controller init done
- sd_wr_req  out  1  write request to controller
- sd_rd_req  out  1  read request to controller
- sd_wr_ack  in  1  controller write accepted
- sd_rd_ack  in  1  controller read accepted
- sd_adr  out  22  controller word address = {1'b0, latched wb_adr}
- sd_wdat  out  16  latched write data
- sd_rdat  in  16  controller read data
- sd_udqm, sd_ldqm  out  1 each  byte masks (1 = masked)
- err  out  1  sticky timeout flag

## Operation
- Reset values: wb_dat_o=0, wb_ack=0, sd_wr_req=0, sd_rd_req=0, sd_adr=0, sd_wdat=0, sd_udqm=0, sd_ldqm=0, err=0, state IDLE.
- IDLE: accept when wb_stb & sd_ready. Latch adr, dat_i, we. Write: udqm=~sel[1], ldqm=~sel[0]. Read: both masks 0 (always full word).
  - Write with sel=00 -> ACK directly, no request issued.
  - Otherwise write -> WREQ, read -> RREQ.
  - If sd_ready=0, no request is issued, regardless of wb_stb.
- WREQ / RREQ: the matching req is held high and the timeout counter increments each cycle.
  - On the matching ack sampled high: drop req. Write -> ACK; read -> RWAIT.
  - The other ack input is ignored.
- RWAIT: count RD_LAT cycles, capture sd_rdat into wb_dat_o on the last one, then -> ACK.
- ACK: internal ack_r=1; wb_ack = ack_r & wb_stb (combinational AND). When wb_stb is sampled low -> IDLE with ack_r cleared.
- Timeout: the counter reaches TIMEOUT in WREQ/RREQ -> drop req, set err, set wb_dat_o=16'hFFFF on reads, -> ACK. err clears only on reset.
- wb_stb dropped mid-transaction: the SDRAM request still runs to completion (or timeout). On reaching ACK with stb already low, return to IDLE the next cycle; wb_ack is never asserted.
- Masks and sd_adr/sd_wdat remain stable from acceptance until the next acceptance.
- Asynchronous reset mid-transaction drops req immediately. The controller is reset by the same rst_n domain.

## Timing
- Cycle 0: wb_stb sampled high in IDLE. Cycle 1: req, sd_adr, sd_wdat and masks are valid, and all are registered.
- Write: ack sampled high at cycle n -> req low and ack_r high at n+1. Minimum latency stb->wb_ack is 2 cycles.
- Read: rd_ack at n -> wb_dat_o updated at n+RD_LAT -> wb_ack at n+RD_LAT+1.
- Write with sel=00: wb_ack at cycle 1.
- Back-to-back: after stb falls, a new stb can be accepted 1 cycle after the return to IDLE, giving a minimum 1 idle cycle between requests.
- Timeout: req is high for exactly TIMEOUT cycles, then wb_ack (if stb high) is asserted the following cycle.

## Test plan
- Reset: hold rst_n=0 while wb_stb=1 -> every output at its reset value and no req. Release with sd_ready=0 -> still no req. Raise sd_ready -> req at the next cycle.
- Word write to adr=21'h012345, data 16'hA5C3, sel=11; controller acks at the 3rd req cycle -> sd_adr=22'h012345, sd_wdat=A5C3, both masks 0, req high exactly 3 cycles, wb_ack one cycle later and held until stb falls.
- Byte writes sel=10 then sel=01 -> (udqm,ldqm)=(0,1) then (1,0). A write with sel=00 -> wb_ack at cycle 1 and no sd_wr_req pulse.
- Read with RD_LAT=2: controller returns 16'h1234 two cycles after rd_ack -> wb_dat_o=1234, masks 00, wb_ack at rd_ack+3.
- Timeout with TIMEOUT=4 and the controller never acking -> req high 4 cycles, err=1, read returns FFFF, wb_ack asserted. The next normal transaction succeeds and err stays 1.
- wb_stb dropped one cycle after acceptance -> req still completes on ack, wb_ack never rises, bridge returns to IDLE, and the next stb is accepted normally.
